// File: rtl/hack_data_memory.sv
// hack_data_memory: data-memory responder for the Hack CPU.
// Memory map (addressM[14:0]): RAM 0x0000..RAM_WORDS-1, screen 0x4000..,
// keyboard at 0x6000, everything else unmapped (reads 0, sets addr_err).
// CPU reads are combinational so M=M+1 completes in one cycle; the display
// scan port is registered with read-before-write semantics.
// Optional build macro: HACK_KBD_FIFO_EN turns the single key register into
// a KBD_DEPTH-entry key FIFO. Default build (undefined) keeps one register.
module hack_data_memory #(
    parameter int RAM_WORDS    = 16384,
    parameter int SCREEN_WORDS = 8192,
    parameter int KBD_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    output logic [15:0] inM,
    input  logic [15:0] key_data,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [12:0] scr_addr,
    output logic [15:0] scr_data,
    output logic        addr_err
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int SCR_AW = $clog2(SCREEN_WORDS);

    localparam logic [14:0] RAM_END  = 15'(RAM_WORDS);
    localparam logic [14:0] SCR_BASE = 15'h4000;
    localparam logic [14:0] SCR_END  = 15'(32'h4000 + SCREEN_WORDS);
    localparam logic [14:0] KBD_ADDR = 15'h6000;

    typedef enum logic [1:0] {
        REG_RAM   = 2'd0,
        REG_SCR   = 2'd1,
        REG_KBD   = 2'd2,
        REG_UNMAP = 2'd3
    } region_t;

    logic [15:0] r_ram    [0:RAM_WORDS-1];
    logic [15:0] r_screen [0:SCREEN_WORDS-1];
    logic [15:0] r_scr_data;
    logic        r_addr_err;

    logic [14:0]       w_a;
    region_t           w_region;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [SCR_AW-1:0] w_scr_idx;
    logic [SCR_AW-1:0] w_scan_idx;
    logic              w_kbd_clr;
    logic [15:0]       w_kbd_val;
    logic              w_key_ready;
    logic              w_unused;

    // Bit 15 is outside the 15-bit Hack space; KBD_DEPTH only matters with the FIFO.
    assign w_unused = ^{addressM[15], 1'(KBD_DEPTH)};

    assign w_a        = addressM[14:0];
    assign w_ram_idx  = w_a[RAM_AW-1:0];
    // The screen base is aligned to the window size, so the low bits are the offset.
    assign w_scr_idx  = w_a[SCR_AW-1:0];
    assign w_scan_idx = scr_addr[SCR_AW-1:0];
    assign w_kbd_clr  = writeM && (w_region == REG_KBD);

    // Address decode into one of the four regions.
    always_comb begin
        w_region = REG_UNMAP;
        if (w_a < RAM_END) begin
            w_region = REG_RAM;
        end else if ((w_a >= SCR_BASE) && (w_a < SCR_END)) begin
            w_region = REG_SCR;
        end else if (w_a == KBD_ADDR) begin
            w_region = REG_KBD;
        end else begin
            w_region = REG_UNMAP;
        end
    end

    // Asynchronous CPU read mux; unmapped addresses read as zero.
    always_comb begin
        inM = 16'h0000;
        case (w_region)
            REG_RAM:   inM = r_ram[w_ram_idx];
            REG_SCR:   inM = r_screen[w_scr_idx];
            REG_KBD:   inM = w_kbd_val;
            REG_UNMAP: inM = 16'h0000;
            default:   inM = 16'h0000;
        endcase
    end

    // RAM write port; reset suppresses a concurrent write, contents are kept.
    always_ff @(posedge clk) begin
        if (!reset && writeM && (w_region == REG_RAM)) begin
            r_ram[w_ram_idx] <= outM;
        end
    end

    // Screen write port; reset suppresses a concurrent write, contents are kept.
    always_ff @(posedge clk) begin
        if (!reset && writeM && (w_region == REG_SCR)) begin
            r_screen[w_scr_idx] <= outM;
        end
    end

    // Registered scan read; a same-cycle CPU write is seen one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scr_data <= 16'h0000;
        end else begin
            r_scr_data <= r_screen[w_scan_idx];
        end
    end

    // Sticky unmapped-access flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_err <= 1'b0;
        end else if (w_region == REG_UNMAP) begin
            r_addr_err <= 1'b1;
        end else begin
            r_addr_err <= r_addr_err;
        end
    end

`ifdef HACK_KBD_FIFO_EN
    localparam int PW = $clog2(KBD_DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(KBD_DEPTH);

    logic [15:0]   r_fifo [0:KBD_DEPTH-1];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    assign w_full      = (r_count == CNT_FULL);
    assign w_empty     = (r_count == '0);
    assign w_key_ready = !w_full;
    // Zero scancodes complete the handshake but are never stored.
    assign w_push      = key_valid && !w_full && (key_data != 16'h0000);
    assign w_pop       = w_kbd_clr && !w_empty;
    assign w_kbd_val   = w_empty ? 16'h0000 : r_fifo[r_rd_ptr];

    // Key FIFO: pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= key_data;
                r_wr_ptr         <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
`else
    logic [15:0] r_kbd;

    assign w_key_ready = (r_kbd == 16'h0000);
    assign w_kbd_val   = r_kbd;

    // Single key register: accept only when empty; accept beats a CPU clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_kbd <= 16'h0000;
        end else if (key_valid && w_key_ready) begin
            r_kbd <= key_data;
        end else if (w_kbd_clr) begin
            r_kbd <= 16'h0000;
        end else begin
            r_kbd <= r_kbd;
        end
    end
`endif

    assign key_ready = w_key_ready;
    assign scr_data  = r_scr_data;
    assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_hack_data_memory.sv
// Scoreboard bench for hack_data_memory: each step drives the inputs, queues
// the values expected for that cycle, and compares them at the falling edge.
module tb_hack_data_memory;

    localparam int S_INM = 0;
    localparam int S_SCR = 1;
    localparam int S_ERR = 2;
    localparam int S_RDY = 3;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic [15:0] key_data;
    logic        key_valid;
    logic        key_ready;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;
    logic        addr_err;

    exp_t sb_q[$];
    int   n_vec    = 0;
    int   n_miscmp = 0;

    hack_data_memory dut (
        .clk       (clk),
        .reset     (reset),
        .addressM  (addressM),
        .outM      (outM),
        .writeM    (writeM),
        .inM       (inM),
        .key_data  (key_data),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .scr_addr  (scr_addr),
        .scr_data  (scr_data),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miscmp++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp_v);
        end
    endtask

    task automatic exp_push(input string tag, input int sel, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic drv(input logic [15:0] a, input logic [15:0] d, input logic w,
                       input logic kv, input logic [15:0] kd, input logic [12:0] sa);
        addressM  = a;
        outM      = d;
        writeM    = w;
        key_valid = kv;
        key_data  = kd;
        scr_addr  = sa;
    endtask

    // Compare queued expectations mid-cycle, then advance past the next edge.
    task automatic step();
        exp_t        e;
        logic [15:0] obs;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                S_INM:   obs = inM;
                S_SCR:   obs = scr_data;
                S_ERR:   obs = {15'h0000, addr_err};
                default: obs = {15'h0000, key_ready};
            endcase
            chk_eq(e.tag, obs, e.val);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drv(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'd5);
        @(posedge clk);
        #1;
        step();
        step();
        reset = 1'b0;

        // Reset state
        drv(16'h6000, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'd5);
        exp_push("rst_kbd", S_INM, 16'h0000);
        exp_push("rst_scr", S_SCR, 16'h0000);
        exp_push("rst_err", S_ERR, 16'h0000);
        exp_push("rst_rdy", S_RDY, 16'h0001);
        step();

        // RAM write / read-back and M=M+1 style update
        drv(16'h0AA1, 16'h0000, 1'b1, 1'b0, 16'h0000, 13'd5);
        step();
        drv(16'h0AA1, 16'h1234, 1'b1, 1'b0, 16'h0000, 13'd5);
        exp_push("ram_before", S_INM, 16'h0000);
        step();
        drv(16'h0AA1, 16'h1235, 1'b1, 1'b0, 16'h0000, 13'd5);
        exp_push("ram_after", S_INM, 16'h1234);
        step();
        drv(16'h0AA1, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'd5);
        exp_push("ram_inc", S_INM, 16'h1235);
        step();
        drv(16'h8AA1, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'd5);
        exp_push("ram_bit15", S_INM, 16'h1235);
        step();
        drv(16'h3FFF, 16'hC3C3, 1'b1, 1'b0, 16'h0000, 13'd5);
        step();
        drv(16'h3FFF, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'd5);
        exp_push("ram_top", S_INM, 16'hC3C3);
        step();

        // Screen write with same-word scan: read-before-write
        drv(16'h4005, 16'h0000, 1'b1, 1'b0, 16'h0000, 13'd5);
        step();
        drv(16'h4005, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'd5);
        step();
        drv(16'h4005, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 13'd5);
        exp_push("scr_pre", S_SCR, 16'h0000);
        step();
        drv(16'h4005, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'd5);
        exp_push("scr_rbw", S_SCR, 16'h0000);
        exp_push("scr_inm", S_INM, 16'hBEEF);
        step();
        drv(16'h4005, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'd5);
        exp_push("scr_new", S_SCR, 16'hBEEF);
        step();
        drv(16'h5FFF, 16'hA5A5, 1'b1, 1'b0, 16'h0000, 13'h1FFF);
        step();
        drv(16'h5FFF, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'h1FFF);
        exp_push("scr_top_inm", S_INM, 16'hA5A5);
        step();
        exp_push("scr_top_scan", S_SCR, 16'hA5A5);
        step();

`ifdef HACK_KBD_FIFO_EN
        // Key FIFO: fill, blocked push with pop, ordered drain
        for (int i = 0; i < 4; i++) begin
            drv(16'h6000, 16'h0000, 1'b0, 1'b1, 16'h0041 + 16'(i), 13'd5);
            exp_push("fifo_rdy_fill", S_RDY, 16'h0001);
            step();
        end
        drv(16'h6000, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'd5);
        exp_push("fifo_full_rdy", S_RDY, 16'h0000);
        exp_push("fifo_head", S_INM, 16'h0041);
        step();
        drv(16'h6000, 16'h0000, 1'b1, 1'b1, 16'h0045, 13'd5);
        exp_push("fifo_full_pop_rdy", S_RDY, 16'h0000);
        exp_push("fifo_full_pop_head", S_INM, 16'h0041);
        step();
        drv(16'h6000, 16'h0000, 1'b0, 1'b1, 16'h0000, 13'd5);
        exp_push("fifo_rdy_after_pop", S_RDY, 16'h0001);
        exp_push("fifo_head2", S_INM, 16'h0042);
        step();
        for (int i = 0; i < 3; i++) begin
            drv(16'h6000, 16'h0000, 1'b1, 1'b0, 16'h0000, 13'd5);
            exp_push("fifo_drain", S_INM, 16'h0042 + 16'(i));
            step();
        end
        drv(16'h6000, 16'h0000, 1'b1, 1'b0, 16'h0000, 13'd5);
        exp_push("fifo_empty", S_INM, 16'h0000);
        step();
        drv(16'h6000, 16'h0000, 1'b0, 1'b1, 16'h0046, 13'd5);
        exp_push("fifo_empty_pop", S_INM, 16'h0000);
        step();
        drv(16'h6000, 16'h0000, 1'b1, 1'b1, 16'h0047, 13'd5);
        exp_push("fifo_pushpop_head", S_INM, 16'h0046);
        step();
        drv(16'h6000, 16'h0000, 1'b1, 1'b0, 16'h0000, 13'd5);
        exp_push("fifo_pushpop_next", S_INM, 16'h0047);
        step();
        drv(16'h6000, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'd5);
        exp_push("fifo_final_empty", S_INM, 16'h0000);
        step();
`else
        // Single key register handshake
        drv(16'h6000, 16'h0000, 1'b0, 1'b1, 16'h0041, 13'd5);
        exp_push("key_rdy_idle", S_RDY, 16'h0001);
        exp_push("key_idle", S_INM, 16'h0000);
        step();
        drv(16'h6000, 16'h0000, 1'b0, 1'b1, 16'h0042, 13'd5);
        exp_push("key_rdy_busy", S_RDY, 16'h0000);
        exp_push("key_41", S_INM, 16'h0041);
        step();
        drv(16'h6000, 16'h0000, 1'b1, 1'b1, 16'h0042, 13'd5);
        exp_push("key_held", S_INM, 16'h0041);
        step();
        drv(16'h6000, 16'h0000, 1'b0, 1'b1, 16'h0042, 13'd5);
        exp_push("key_rdy_cleared", S_RDY, 16'h0001);
        exp_push("key_cleared", S_INM, 16'h0000);
        step();
        drv(16'h6000, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'd5);
        exp_push("key_42", S_INM, 16'h0042);
        exp_push("key_rdy_42", S_RDY, 16'h0000);
        step();
        drv(16'h6000, 16'h0000, 1'b1, 1'b0, 16'h0000, 13'd5);
        step();
        drv(16'h6000, 16'h0000, 1'b0, 1'b1, 16'h0000, 13'd5);
        exp_push("key_zero_rdy", S_RDY, 16'h0001);
        step();
        drv(16'h6000, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'd5);
        exp_push("key_zero_store", S_INM, 16'h0000);
        exp_push("key_zero_rdy2", S_RDY, 16'h0001);
        step();
        drv(16'h6000, 16'h0000, 1'b1, 1'b1, 16'h0043, 13'd5);
        step();
        drv(16'h6000, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'd5);
        exp_push("key_accept_wins", S_INM, 16'h0043);
        step();
        drv(16'h6000, 16'h0000, 1'b1, 1'b0, 16'h0000, 13'd5);
        step();
`endif

        // Unmapped access sets the sticky error flag
        drv(16'h6001, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 13'd5);
        exp_push("unmap_inm", S_INM, 16'h0000);
        exp_push("unmap_err_pre", S_ERR, 16'h0000);
        step();
        drv(16'h0AA1, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'd5);
        exp_push("unmap_err_set", S_ERR, 16'h0001);
        exp_push("unmap_ram_ok", S_INM, 16'h1235);
        step();
        drv(16'h4005, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'd5);
        exp_push("unmap_err_sticky", S_ERR, 16'h0001);
        step();

        // Reset mid-operation
        drv(16'h0010, 16'h1111, 1'b1, 1'b0, 16'h0000, 13'd5);
        step();
        drv(16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'd5);
        exp_push("pre_rst_ram", S_INM, 16'h1111);
        step();
        drv(16'h6000, 16'h0000, 1'b0, 1'b1, 16'h0055, 13'd5);
        exp_push("pre_rst_rdy", S_RDY, 16'h0001);
        step();
        drv(16'h6000, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'd5);
        exp_push("pre_rst_key", S_INM, 16'h0055);
        step();
        reset = 1'b1;
        drv(16'h0010, 16'h5555, 1'b1, 1'b1, 16'h0077, 13'd5);
        step();
        reset = 1'b0;
        drv(16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'd5);
        exp_push("rst_write_supp", S_INM, 16'h1111);
        exp_push("rst2_scr", S_SCR, 16'h0000);
        exp_push("rst2_err", S_ERR, 16'h0000);
        exp_push("rst2_rdy", S_RDY, 16'h0001);
        step();
        drv(16'h6000, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'd5);
        exp_push("rst2_kbd", S_INM, 16'h0000);
        step();
        drv(16'h0AA1, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'd5);
        exp_push("rst2_ram_keep", S_INM, 16'h1235);
        step();
        drv(16'h4005, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'd5);
        exp_push("rst2_scr_keep", S_INM, 16'hBEEF);
        exp_push("rst2_scan_keep", S_SCR, 16'hBEEF);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/hack_data_memory.md
Name: hack_data_memory

Overview:
- Data-memory responder for the Hack CPU: receives addressM/outM/writeM and returns inM.
- Implements the Hack memory map:
  - RAM at 0x0000-0x3FFF
  - Screen at 0x4000-0x5FFF
  - Keyboard register at 0x6000
- Adds a producer-side key handshake and a registered screen-scan read port for the display driver.
- Sits between cpu and the top-level I/O.

Parameters:
- RAM_WORDS, 16384, words of general RAM; fixes the RAM window at 0x0000..RAM_WORDS-1.
- SCREEN_WORDS, 8192, words of screen memory at 0x4000..0x4000+SCREEN_WORDS-1.
- KBD_DEPTH, 4, key FIFO depth; used only with HACK_KBD_FIFO_EN; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- addressM  input  16  CPU data address; bit 15 is ignored (15-bit Hack space).
- outM  input  16  CPU write data.
- writeM  input  1  CPU write strobe, sampled at the rising edge.
- inM  output  16  read data for addressM; combinational, same cycle.
- key_data  input  16  scancode from the keyboard front end.
- key_valid  input  1  key_data is valid.
- key_ready  output  1  block can accept a key; transfer occurs when key_valid && key_ready at the edge.
- scr_addr  input  13  screen scan word index.
- scr_data  output  16  screen word at scr_addr; registered, 1-cycle latency.
- addr_err  output  1  sticky flag: an access hit an unmapped address.

Behaviour:
- Decode uses a = addressM[14:0]:
  - RAM: a < 0x4000.
  - SCREEN: 0x4000 <= a < 0x6000.
  - KBD: a == 0x6000.
  - Anything else is UNMAPPED.
- Reads are asynchronous:
  - inM reflects the current array/register contents for the current addressM in the same cycle. The CPU executes M=M+1 in one cycle on this basis.
  - UNMAPPED reads return 0x0000.
- RAM/SCREEN writes:
  - When writeM=1, the addressed word takes outM at the rising edge.
  - inM shows the new value from the next cycle.
- Write to KBD: writeM=1 at 0x6000 clears (pops) the key register; the outM value is ignored.
- UNMAPPED accesses:
  - A write is discarded.
  - Any UNMAPPED access with writeM=1, or an UNMAPPED read, sets addr_err at the next edge.
  - addr_err is cleared only by reset.
- Screen scan port:
  - scr_data <= screen[scr_addr] each cycle.
  - Read-before-write: if the CPU writes the same screen word in the same cycle, scr_data returns the old value.
  - The new value appears one cycle later.
- Key register (macro off):
  - key_ready = (kbd == 0).
  - On key_valid && key_ready, kbd <= key_data.
  - key_data == 0x0000 completes the handshake and stores nothing.
  - If the CPU clears KBD in the same cycle a key is accepted, the accept wins (possible only when kbd == 0, so the clear is a no-op).
- Reset:
  - kbd = 0, scr_data = 0, addr_err = 0, key_ready = 1 in the cycle after reset is sampled.
  - Reset overrides concurrent writes and key handshakes.
  - RAM and screen contents are NOT cleared.
  - Reset asserted mid-write suppresses that write.
- Width rules: all data is 16-bit with no arithmetic. Indices are truncated to the region size after decode.

Optional Feature:
- Macro: HACK_KBD_FIFO_EN.
- Defined:
  - The key register becomes a KBD_DEPTH-entry FIFO.
  - KBD reads the head entry, or 0 when empty.
  - A write to KBD pops one entry; a pop when empty is ignored.
  - key_ready = !full.
  - Push and pop in the same cycle are both performed. When full, no push occurs, even with a concurrent pop.
  - Zero scancodes are dropped.
  - Pointers wrap modulo KBD_DEPTH.
  - Reset empties the FIFO.
- Undefined: single-register behaviour as described in Behaviour.

Test Plan:
1. Write 0x1234 to 0x0AA1, then read it back.
   - inM = 0x0000 before the write edge and 0x1234 after it.
   - An M=M+1 style sequence (write 0x1235 in the next cycle) reads back 0x1235.
2. Screen write and scan at the same word:
   - Write 0xBEEF to 0x4005 with scr_addr = 5 in the same cycle.
   - scr_data shows the old value, then 0xBEEF one cycle later.
   - inM at 0x4005 = 0xBEEF.
3. Key handshake, macro off:
   - key_valid with 0x0041: accepted and key_ready drops.
   - inM at 0x6000 = 0x0041.
   - A second key 0x0042 is held off.
   - A CPU write to 0x6000 clears the register; 0x0042 is accepted the next cycle.
4. Key FIFO, macro on:
   - Push 4 keys (0x41-0x44): key_ready low after the fourth.
   - A fifth key with a concurrent pop is not accepted in that cycle.
   - Pops read 0x41, 0x42, 0x43, 0x44 in order, then 0x0000.
5. Unmapped access:
   - Write 0xFFFF to 0x6001: inM = 0 at 0x6001 and addr_err = 1 next cycle.
   - addr_err stays 1 through later valid accesses until reset.
6. Reset mid-operation:
   - Assert reset with writeM = 1 to 0x0010 (0x5555) and key_valid high.
   - The word is unchanged, kbd = 0, scr_data = 0, addr_err = 0 and key_ready = 1.
   - Prior RAM data is retained.
